scan_cfg_loader: RTL and testbench
==================================

SCAN_CFG_LOADER -- requirements
Module: scan_cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 128: number of scff cells in the target scan chain (legal 1..4096).
REQ-002 SHALL have parameter WORD_W, default 16: configuration word width, one frac_lut4 LUT mask per word.
REQ-003 SHALL have port C, input, 1: sole clock; all state updates on posedge C.
REQ-004 SHALL have port R, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: begin a load sequence; sampled in IDLE only.
REQ-006 SHALL have port in_data, input, WORD_W: configuration word; bit 0 is shifted first.
REQ-007 SHALL have port in_valid, input, 1: in_data valid.
REQ-008 SHALL have port in_ready, output, 1: loader accepts in_data this cycle.
REQ-009 SHALL have port sc_en, output, 1: chain shift enable, gating the scff clock.
REQ-010 SHALL have port sc_dout, output, 1: serial data into the chain head.
REQ-011 SHALL have port sc_din, input, 1: serial data from the chain tail, used for readback.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the sequence completes.
REQ-014 SHALL have port rd_data, output, WORD_W: readback word.
REQ-015 SHALL have port rd_valid, output, 1: one-cycle qualifier for rd_data.

Function
REQ-016 SHALL implement states IDLE, LOAD, SHIFT, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-017 IDLE: start=1 SHALL clear the total-bit counter and move to LOAD next cycle; start SHALL be ignored in any other state.
REQ-018 LOAD: in_ready SHALL be 1; on in_valid&in_ready, in_data SHALL be captured and the state SHALL move to SHIFT; without in_valid the FSM SHALL remain in LOAD indefinitely with sc_en=0.
REQ-019 SHIFT: sc_en SHALL be 1 and sc_dout SHALL equal the current word bit k, with k incrementing by 1 each cycle starting at 0.
REQ-020 SHIFT SHALL end after WORD_W cycles or when the total-bit count reaches CHAIN_LEN, whichever is first; the next state SHALL be DONE if the total equals CHAIN_LEN, otherwise LOAD.
REQ-021 If CHAIN_LEN is not a multiple of WORD_W, the upper bits of the final word SHALL be discarded and never appear on sc_dout.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a start pulse during DONE SHALL be ignored.
REQ-023 Per word, with in_valid held high, the loader SHALL spend 1 LOAD cycle and WORD_W SHIFT cycles; for CHAIN_LEN=128 and start in cycle t, done SHALL be high in cycle t+137.
REQ-024 sc_en and in_ready SHALL never be high in the same cycle.
REQ-025 The total-bit counter SHALL be wide enough for CHAIN_LEN and SHALL never wrap.

Reset
REQ-026 R=0 at a posedge of C SHALL force IDLE and set in_ready=0, sc_en=0, sc_dout=0, busy=0, done=0, rd_valid=0, rd_data=0, and all counters to 0.
REQ-027 Reset during SHIFT SHALL abort immediately, with sc_en=0 in the first cycle after reset; the partially loaded chain is not restored, and no done or rd_valid SHALL be emitted for the aborted sequence.

Configuration
REQ-028 Macro SCAN_READBACK_EN SHALL compile in readback; without it, sc_din SHALL be ignored and rd_data=0 and rd_valid=0 constantly.
REQ-029 With SCAN_READBACK_EN, sc_din SHALL be sampled on every cycle with sc_en=1, and sample k of a word SHALL go to rd_data bit k.
REQ-030 With SCAN_READBACK_EN, rd_valid SHALL pulse in the cycle after the last SHIFT cycle of each word, and a partial final word SHALL be zero-padded in its upper bits.

Verification
REQ-031 CHAIN_LEN=32, words 16'hA5C3 then 16'h00FF with in_valid always high -> sc_dout sequence = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 then 8 ones and 8 zeros; done exactly once, in cycle t+35.
REQ-032 CHAIN_LEN=20, words 16'hFFFF and 16'h000F -> exactly 20 sc_en cycles; last 4 sc_dout bits = 1; the upper 12 bits of the second word are never driven.
REQ-033 in_valid withheld for 10 cycles in LOAD -> in_ready held at 1, sc_en=0 throughout, busy=1; the sequence resumes on the next valid word.
REQ-034 R=0 at the 5th SHIFT cycle -> next cycle IDLE, busy=0, sc_en=0, no done pulse; a new start then completes normally.
REQ-035 SCAN_READBACK_EN, CHAIN_LEN=16, sc_din looped through a 16-deep model chain preloaded with 16'h1234, loading 16'hBEEF -> rd_data=16'h1234 with rd_valid for one cycle; a second load of any word returns 16'hBEEF.
REQ-036 start pulsed during SHIFT and during DONE -> ignored, with exactly one done per accepted start.

Source files
------------

// File: rtl/scan_cfg_loader.sv
// scan_cfg_loader: streams WORD_W-bit configuration words, LSB first, into
// a CHAIN_LEN-long scff scan chain, then pulses done.
// Optional build macro SCAN_READBACK_EN adds readback of the chain tail
// (sc_din) into rd_data/rd_valid. Without it, sc_din is ignored and rd_data
// and rd_valid are held at zero.
module scan_cfg_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 16
) (
    input  logic              C,
    input  logic              R,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sc_en,
    output logic              sc_dout,
    input  logic              sc_din,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid
);

    // The total-bit counter holds 0..CHAIN_LEN and stops there, so it never wraps.
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_TOTAL = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] word_q;     // bits still waiting to be shifted out
    logic [BIT_W-1:0]  bit_idx;    // position k within the current word
    logic [CNT_W-1:0]  total_cnt;  // bits shifted in this sequence
    logic              last_bit;
    logic              last_total;

    assign last_bit   = (bit_idx == LAST_BIT);
    assign last_total = (total_cnt == LAST_TOTAL);

    // Control FSM. Every output is registered together with the state
    // transition that implies it, so no output depends on live inputs.
    always_ff @(posedge C) begin
        // NOTE: the reset is synchronous (sampled only at the clock edge), and all
        // state uses non-blocking assignments so every register sees pre-edge values.
        if (!R) begin
            state     <= IDLE;
            word_q    <= '0;
            bit_idx   <= '0;
            total_cnt <= '0;
            in_ready  <= 1'b0;
            sc_en     <= 1'b0;
            sc_dout   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        total_cnt <= '0;
                        state     <= LOAD;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        word_q   <= in_data >> 1;
                        sc_dout  <= in_data[0];
                        bit_idx  <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        sc_en    <= 1'b1;
                    end
                end
                SHIFT: begin
                    total_cnt <= total_cnt + 1'b1;
                    bit_idx   <= bit_idx + 1'b1;
                    word_q    <= word_q >> 1;
                    sc_dout   <= word_q[0];
                    if (last_bit || last_total) begin
                        // Leaving SHIFT early drops the unused upper bits of
                        // a partial final word; they never reach sc_dout.
                        sc_en   <= 1'b0;
                        sc_dout <= 1'b0;
                        if (last_total) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_READBACK_EN
    logic [WORD_W-1:0] rd_shift;  // tail samples of the word in flight

    // Readback: sample k of a word lands in bit k; the word is published with a
    // one-cycle rd_valid after its last SHIFT cycle, zero-padded if partial.
    always_ff @(posedge C) begin
        if (!R) begin
            rd_shift <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == LOAD) begin
                rd_shift <= '0;
            end else if (sc_en) begin
                rd_shift[bit_idx] <= sc_din;
                if (last_bit || last_total) begin
                    rd_data  <= rd_shift | (WORD_W'(sc_din) << bit_idx);
                    rd_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_sc_din;

    assign unused_sc_din = sc_din;
    assign rd_data       = '0;
    assign rd_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Bench for scan_cfg_loader: four instances (CHAIN_LEN 32, 20, 16, 128).
// Expected shift bits and readback words are queued when a word is handed to
// the loader and popped as the loader produces them.
module tb_scan_cfg_loader;

    localparam int N  = 4;
    localparam int WW = 16;
    localparam int BUDGET = 400;

    logic          C = 1'b0;
    logic          R;
    logic          start    [N];
    logic [WW-1:0] in_data  [N];
    logic          in_valid [N];
    logic          in_ready [N];
    logic          sc_en    [N];
    logic          sc_dout  [N];
    logic          sc_din   [N];
    logic          busy     [N];
    logic          done     [N];
    logic [WW-1:0] rd_data  [N];
    logic          rd_valid [N];

    int n_checks = 0;
    int n_fail   = 0;

    bit            exp_bits [$];
    logic [WW-1:0] exp_rd   [$];

    logic          preload2;
    logic [WW-1:0] chain2;
    logic [WW-1:0] shadow2;

    always #5 C = ~C;

    function automatic int clen_of(input int g);
        case (g)
            0:       return 32;
            1:       return 20;
            2:       return 16;
            default: return 128;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        scan_cfg_loader #(
            .CHAIN_LEN(clen_of(g)),
            .WORD_W   (WW)
        ) u_dut (
            .C       (C),
            .R       (R),
            .start   (start[g]),
            .in_data (in_data[g]),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .sc_en   (sc_en[g]),
            .sc_dout (sc_dout[g]),
            .sc_din  (sc_din[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .rd_data (rd_data[g]),
            .rd_valid(rd_valid[g])
        );
    end

    // 16-deep chain model on instance 2: head takes sc_dout, tail is chain2[0].
    always @(posedge C) begin
        if (preload2)
            chain2 <= 16'h1234;
        else if (sc_en[2])
            chain2 <= {sc_dout[2], chain2[WW-1:1]};
    end

    assign sc_din[0] = 1'b1;
    assign sc_din[1] = 1'b1;
    assign sc_din[2] = chain2[0];
    assign sc_din[3] = 1'b1;

    task automatic step();
        @(posedge C);
        #1;
    endtask

    // One load sequence on instance idx; word 0 is w0, every later word is w1.
    task automatic run_seq(input string name, input int idx,
                           input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input int gap, input bit noise, input int abort_at,
                           input int exp_done, input int exp_en);
        int            c;
        int            en_cnt;
        int            n_done;
        int            done_cyc;
        int            pushed;
        int            words;
        int            gap_left;
        int            clen;
        int            nb;
        bit            b;
        bit            prev_rdv;
        bit            aborted;
        logic [WW-1:0] w;
        logic [WW-1:0] rmask;
        logic [WW-1:0] got_rd;

        clen     = clen_of(idx);
        en_cnt   = 0;
        n_done   = 0;
        done_cyc = -1;
        pushed   = 0;
        words    = 0;
        gap_left = gap;
        prev_rdv = 1'b0;
        aborted  = 1'b0;
        exp_bits.delete();
        exp_rd.delete();

        start[idx]    = 1'b1;
        in_valid[idx] = 1'b0;
        step();
        start[idx] = 1'b0;
        c = 1;
        while (c < BUDGET) begin
            n_checks++;
            if (sc_en[idx] && in_ready[idx]) begin
                n_fail++;
                $display("FAIL %s en_ready_overlap cycle %0d: sc_en=%b in_ready=%b, want not both 1",
                         name, c, sc_en[idx], in_ready[idx]);
            end
            if (sc_en[idx] === 1'b1) begin
                en_cnt++;
                n_checks++;
                if (exp_bits.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_shift cycle %0d: sc_en=1 but no bit expected", name, c);
                end else begin
                    b = exp_bits.pop_front();
                    if (sc_dout[idx] !== b) begin
                        n_fail++;
                        $display("FAIL %s sc_dout shift %0d: got %b want %b", name, en_cnt, sc_dout[idx], b);
                    end
                end
            end
            if (done[idx] === 1'b1) begin
                n_done++;
                if (n_done == 1) done_cyc = c;
            end
`ifdef SCAN_READBACK_EN
            if (rd_valid[idx] === 1'b1) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_rd_valid cycle %0d", name, c);
                end else begin
                    w      = exp_rd.pop_front();
                    got_rd = rd_data[idx];
                    if (got_rd !== w) begin
                        n_fail++;
                        $display("FAIL %s rd_data: got %h want %h", name, got_rd, w);
                    end
                end
                n_checks++;
                if (prev_rdv) begin
                    n_fail++;
                    $display("FAIL %s rd_valid_pulse cycle %0d: high two cycles, want one", name, c);
                end
            end
            prev_rdv = (rd_valid[idx] === 1'b1);
`else
            n_checks++;
            if (rd_valid[idx] !== 1'b0 || rd_data[idx] !== '0) begin
                n_fail++;
                $display("FAIL %s rd_disabled cycle %0d: rd_valid=%b rd_data=%h want 0/0",
                         name, c, rd_valid[idx], rd_data[idx]);
            end
`endif
            // Drive the next cycle's inputs from what was just observed.
            in_valid[idx] = 1'b0;
            in_data[idx]  = 16'hDEAD;
            if (in_ready[idx] === 1'b1) begin
                if (words >= 1 && gap_left > 0) begin
                    gap_left--;
                    n_checks++;
                    if (busy[idx] !== 1'b1 || sc_en[idx] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s stall cycle %0d: busy=%b sc_en=%b want 1/0",
                                 name, c, busy[idx], sc_en[idx]);
                    end
                end else begin
                    w = (words == 0) ? w0 : w1;
                    in_valid[idx] = 1'b1;
                    in_data[idx]  = w;
                    nb    = (clen - pushed < WW) ? clen - pushed : WW;
                    rmask = '0;
                    for (int k = 0; k < nb; k++) begin
                        exp_bits.push_back(w[k]);
                        rmask[k] = 1'b1;
                    end
                    if (idx == 2) begin
                        exp_rd.push_back(shadow2);
                        shadow2 = w;
                    end else begin
                        exp_rd.push_back(rmask);
                    end
                    pushed += nb;
                    words++;
                end
            end
            start[idx] = noise && (busy[idx] === 1'b1);

            if (abort_at > 0 && sc_en[idx] === 1'b1 && en_cnt == abort_at) begin
                R             = 1'b0;
                in_valid[idx] = 1'b0;
                start[idx]    = 1'b0;
                step();
                n_checks++;
                if (busy[idx] !== 1'b0 || sc_en[idx] !== 1'b0 || in_ready[idx] !== 1'b0 ||
                    done[idx] !== 1'b0 || rd_valid[idx] !== 1'b0 || sc_dout[idx] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s abort_state: busy=%b sc_en=%b in_ready=%b done=%b rd_valid=%b sc_dout=%b want all 0",
                             name, busy[idx], sc_en[idx], in_ready[idx], done[idx], rd_valid[idx], sc_dout[idx]);
                end
                R = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    step();
                    n_checks++;
                    if (done[idx] !== 1'b0 || rd_valid[idx] !== 1'b0 || busy[idx] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s post_abort cycle %0d: done=%b rd_valid=%b busy=%b want 0/0/0",
                                 name, k, done[idx], rd_valid[idx], busy[idx]);
                    end
                end
                aborted = 1'b1;
                break;
            end

            if (n_done > 0 && c >= done_cyc + 3) begin
                n_checks++;
                if (busy[idx] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s idle_after_done: busy=%b want 0", name, busy[idx]);
                end
                break;
            end
            step();
            c++;
        end
        start[idx]    = 1'b0;
        in_valid[idx] = 1'b0;

        if (aborted) begin
            exp_bits.delete();
            exp_rd.delete();
        end else begin
            n_checks++;
            if (n_done != 1) begin
                n_fail++;
                $display("FAIL %s done_count: got %0d want 1", name, n_done);
            end
            n_checks++;
            if (done_cyc != exp_done) begin
                n_fail++;
                $display("FAIL %s done_cycle: got t+%0d want t+%0d", name, done_cyc, exp_done);
            end
            n_checks++;
            if (en_cnt != exp_en) begin
                n_fail++;
                $display("FAIL %s sc_en_cycles: got %0d want %0d", name, en_cnt, exp_en);
            end
            n_checks++;
            if (exp_bits.size() != 0) begin
                n_fail++;
                $display("FAIL %s bits_left: got %0d unshifted want 0", name, exp_bits.size());
            end
`ifdef SCAN_READBACK_EN
            n_checks++;
            if (exp_rd.size() != 0) begin
                n_fail++;
                $display("FAIL %s rd_left: got %0d missing words want 0", name, exp_rd.size());
            end
`endif
        end
        step();
    endtask

    task automatic test_reset();
        R = 1'b0;
        step();
        step();
        for (int g = 0; g < N; g++) begin
            n_checks++;
            if (in_ready[g] !== 1'b0 || sc_en[g] !== 1'b0 || sc_dout[g] !== 1'b0 || busy[g] !== 1'b0 ||
                done[g] !== 1'b0 || rd_valid[g] !== 1'b0 || rd_data[g] !== '0) begin
                n_fail++;
                $display("FAIL reset inst %0d: in_ready=%b sc_en=%b sc_dout=%b busy=%b done=%b rd_valid=%b rd_data=%h want all 0",
                         g, in_ready[g], sc_en[g], sc_dout[g], busy[g], done[g], rd_valid[g], rd_data[g]);
            end
        end
        R = 1'b1;
        step();
    endtask

    task automatic test_pattern();
        run_seq("pattern_32", 0, 16'hA5C3, 16'h00FF, 0, 1'b0, 0, 35, 32);
    endtask

    task automatic test_partial_word();
        run_seq("partial_20", 1, 16'hFFFF, 16'h000F, 0, 1'b0, 0, 23, 20);
        run_seq("partial_20_hi", 1, 16'h0F0F, 16'hFFF5, 0, 1'b0, 0, 23, 20);
    endtask

    task automatic test_load_stall();
        run_seq("load_stall", 0, 16'h1234, 16'hABCD, 10, 1'b0, 0, 45, 32);
    endtask

    task automatic test_reset_abort();
        run_seq("abort", 0, 16'h5A5A, 16'h3C3C, 0, 1'b0, 5, 0, 0);
        run_seq("after_abort", 0, 16'hC001, 16'h8E71, 0, 1'b0, 0, 35, 32);
    endtask

    task automatic test_start_ignored();
        run_seq("start_noise", 0, 16'h6B29, 16'hF00D, 0, 1'b1, 0, 35, 32);
    endtask

    task automatic test_readback();
        preload2 = 1'b1;
        step();
        preload2 = 1'b0;
        shadow2  = 16'h1234;
        run_seq("readback_1", 2, 16'hBEEF, 16'hBEEF, 0, 1'b0, 0, 18, 16);
        run_seq("readback_2", 2, 16'h5A5A, 16'h5A5A, 0, 1'b0, 0, 18, 16);
    endtask

    task automatic test_full_chain();
        run_seq("chain_128", 3, 16'h8421, 16'h7E18, 0, 1'b0, 0, 137, 128);
    endtask

    initial begin
        R        = 1'b0;
        preload2 = 1'b0;
        shadow2  = '0;
        for (int g = 0; g < N; g++) begin
            start[g]    = 1'b0;
            in_valid[g] = 1'b0;
            in_data[g]  = '0;
        end
        test_reset();
        test_pattern();
        test_partial_word();
        test_load_stall();
        test_reset_abort();
        test_start_ignored();
        test_readback();
        test_full_chain();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
